// File: rtl/dds_cmd_master_pkg.sv
// Shared command codes, error codes and byte-sequencing helper
// for the DDS command initiator.
`timescale 1ns/1ps
package dds_cmd_master_pkg;

  localparam logic [7:0] CMD_BYTE0   = 8'h01;
  localparam logic [7:0] CMD_BYTE1   = 8'h02;
  localparam logic [7:0] CMD_BYTE2   = 8'h03;
  localparam logic [7:0] CMD_BYTE3   = 8'h04;
  localparam logic [7:0] CMD_SET     = 8'h05;
  localparam logic [7:0] CMD_ENABLE  = 8'h06;
  localparam logic [7:0] CMD_DISABLE = 8'h07;
  localparam logic [7:0] CMD_ACK     = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BADRSP  = 2'd2;

  localparam logic [2:0] LAST_STEP   = 3'd5;

  // phase 0 is the command byte, phase 1 the data byte (steps 0-3 only)
  function automatic logic [7:0] step_byte(
    input logic [2:0]  step,
    input logic        phase,
    input logic [31:0] m,
    input logic        en
  );
    logic [7:0] b;
    b = CMD_SET;
    case (step)
      3'd0:    b = phase ? m[7:0]   : CMD_BYTE0;
      3'd1:    b = phase ? m[15:8]  : CMD_BYTE1;
      3'd2:    b = phase ? m[23:16] : CMD_BYTE2;
      3'd3:    b = phase ? m[31:24] : CMD_BYTE3;
      3'd4:    b = CMD_SET;
      default: b = en ? CMD_ENABLE : CMD_DISABLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dds_cmd_master_if.sv
// Controller and UART-side signal bundle of the DDS command initiator.
`timescale 1ns/1ps
interface dds_cmd_master_if;
  logic        start;
  logic [31:0] m_in;
  logic        en_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        received;
  logic [7:0]  rx_byte;

  modport master (
    input  start, m_in, en_in,
    input  tx_busy, received, rx_byte,
    output busy, done, err, err_code,
    output transmit, tx_byte
  );

  modport slave (
    output start, m_in, en_in,
    output tx_busy, received, rx_byte,
    input  busy, done, err, err_code,
    input  transmit, tx_byte
  );
endinterface

// File: rtl/dds_cmd_master_ack_watchdog.sv
// ACK flag, bad-response detect and saturating timeout counter,
// armed from the transmit pulse of a command's last byte.
`timescale 1ns/1ps
module dds_cmd_master_ack_watchdog
  import dds_cmd_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1200000,
  parameter int CNT_W       = $clog2(ACK_TIMEOUT+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arm,
  input  logic       i_disarm,
  input  logic       i_received,
  input  logic [7:0] i_rx_byte,
  output logic       o_ack_ok,
  output logic       o_bad_rsp,
  output logic       o_timeout
);

  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(ACK_TIMEOUT);

  logic             r_armed;
  logic             r_ack;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_miss;

  assign w_hit  = r_armed && i_received && (i_rx_byte == CMD_ACK);
  assign w_miss = r_armed && i_received && (i_rx_byte != CMD_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
    end else if (i_arm) begin
      r_armed <= 1'b1;
      r_ack   <= 1'b0;
      r_cnt   <= TO_LOAD;
    end else if (i_disarm) begin
      r_armed <= 1'b0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_armed) begin
      if (w_hit) r_ack <= 1'b1;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // a same-cycle ACK counts so it beats a simultaneous expiry
  assign o_ack_ok  = r_ack || w_hit;
  assign o_bad_rsp = w_miss;
  assign o_timeout = r_armed && (r_cnt == '0);

endmodule

// File: rtl/dds_cmd_master.sv
// UART command initiator: sends a tuning word, SET and ENABLE/DISABLE,
// waiting for an ACK after each complete command.
`timescale 1ns/1ps
module dds_cmd_master
  import dds_cmd_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1200000,
  parameter int CNT_W       = $clog2(ACK_TIMEOUT+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  dds_cmd_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_GUARD,
    S_WAIT_TX, S_WAIT_ACK, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [2:0]  r_step;
  logic        r_phase;
  logic [31:0] r_m;
  logic        r_en;
  logic        r_transmit;
  logic [7:0]  r_tx_byte;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_last;
  logic        w_arm;
  logic        w_disarm;
  logic        w_ack_ok;
  logic        w_bad_rsp;
  logic        w_timeout;
  logic        w_fail;
  logic [1:0]  w_code;

  assign w_last   = (r_step >= 3'd4) || r_phase;
  assign w_arm    = (r_state == S_SEND) && !bus.tx_busy && w_last;
  assign w_disarm = r_state inside {S_IDLE, S_LOAD, S_DONE, S_ERR};

  dds_cmd_master_ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wd (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_arm      (w_arm),
    .i_disarm   (w_disarm),
    .i_received (bus.received),
    .i_rx_byte  (bus.rx_byte),
    .o_ack_ok   (w_ack_ok),
    .o_bad_rsp  (w_bad_rsp),
    .o_timeout  (w_timeout)
  );

  always_comb begin
    w_fail = 1'b0;
    w_code = ERR_NONE;
    if (r_state inside {S_GUARD, S_WAIT_TX, S_WAIT_ACK} &&
        !(r_state == S_WAIT_ACK && w_ack_ok)) begin
      if (w_bad_rsp) begin
        w_fail = 1'b1;
        w_code = ERR_BADRSP;
      end else if (r_state == S_WAIT_ACK && w_timeout) begin
        w_fail = 1'b1;
        w_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= 3'd0;
      r_phase    <= 1'b0;
      r_m        <= 32'd0;
      r_en       <= 1'b0;
      r_transmit <= 1'b0;
      r_tx_byte  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_transmit <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_fail) begin
        r_state    <= S_ERR;
        r_err      <= 1'b1;
        r_busy     <= 1'b0;
        r_err_code <= w_code;
      end else begin
        unique case (r_state)
          S_IDLE: if (bus.start) begin
            r_m        <= bus.m_in;
            r_en       <= bus.en_in;
            r_busy     <= 1'b1;
            r_err_code <= ERR_NONE;
            r_step     <= 3'd0;
            r_phase    <= 1'b0;
            r_state    <= S_LOAD;
          end
          S_LOAD: begin
            r_tx_byte <= step_byte(r_step, r_phase, r_m, r_en);
            r_state   <= S_SEND;
          end
          S_SEND: if (!bus.tx_busy) begin
            r_transmit <= 1'b1;
            r_state    <= S_GUARD;
          end
          // UART raises tx_busy a cycle late, so skip one look
          S_GUARD: r_state <= S_WAIT_TX;
          S_WAIT_TX: if (!bus.tx_busy) begin
            if (w_last) begin
              r_state <= S_WAIT_ACK;
            end else begin
              r_phase <= 1'b1;
              r_state <= S_LOAD;
            end
          end
          S_WAIT_ACK: if (w_ack_ok) begin
            r_phase <= 1'b0;
            if (r_step == LAST_STEP) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= S_LOAD;
            end
          end
          S_DONE: r_state <= S_IDLE;
          S_ERR:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.transmit = r_transmit;
  assign bus.tx_byte  = r_tx_byte;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_dds_cmd_master.sv
// Scoreboard bench for dds_cmd_master with a behavioural UART/responder.
`timescale 1ns/1ps
module tb_dds_cmd_master;
  import dds_cmd_master_pkg::*;

  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_cmd_master_if ifc();

  dds_cmd_master #(.ACK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [3:0] evt_q[$];
  int n_tx = 0;
  int byte_idx = 0;
  int ack_delay = 20;
  int no_ack_idx = -1;
  int bad_idx = -1;
  int last_tx_cyc = 0;
  int last_evt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  function automatic bit is_last(input int i);
    return (i == 1) || (i == 3) || (i == 5) || (i == 7) || (i >= 8);
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] m,
                                          input logic en);
    logic [7:0] b;
    case (i)
      0: b = CMD_BYTE0;
      1: b = m[7:0];
      2: b = CMD_BYTE1;
      3: b = m[15:8];
      4: b = CMD_BYTE2;
      5: b = m[23:16];
      6: b = CMD_BYTE3;
      7: b = m[31:24];
      8: b = CMD_SET;
      default: b = en ? CMD_ENABLE : CMD_DISABLE;
    endcase
    return b;
  endfunction

  // UART tx busy for 10 cycles per byte; responder replies after each command
  initial begin
    int busy_cnt;
    int ack_cnt;
    logic [7:0] ack_val;
    busy_cnt = 0;
    ack_cnt = 0;
    ack_val = CMD_ACK;
    ifc.tx_busy = 1'b0;
    ifc.received = 1'b0;
    ifc.rx_byte = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ifc.received = 1'b0;
      if (!rst_n) begin
        busy_cnt = 0;
        ack_cnt = 0;
      end else begin
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            ifc.received = 1'b1;
            ifc.rx_byte = ack_val;
          end
        end
        if (ifc.transmit) begin
          if (is_last(byte_idx) && byte_idx != no_ack_idx) begin
            ack_cnt = ack_delay;
            ack_val = (byte_idx == bad_idx) ? 8'h55 : CMD_ACK;
          end
          byte_idx++;
          busy_cnt = 10;
        end
      end
      ifc.tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  // monitor: pops expectations whenever the DUT presents an output event
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ifc.transmit) begin
        n_tx++;
        last_tx_cyc = cyc;
        if (exp_q.size() == 0) flag("tx_extra", 32'(ifc.tx_byte));
        else check("tx_byte", 32'(ifc.tx_byte), 32'(exp_q.pop_front()));
      end
      if (rst_n && (ifc.done || ifc.err)) begin
        last_evt_cyc = cyc;
        if (evt_q.size() == 0)
          flag("evt_extra", 32'({ifc.done, ifc.err, ifc.err_code}));
        else
          check("done_err_code", 32'({ifc.done, ifc.err, ifc.err_code}),
                32'(evt_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected finish", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic start_cmd(input logic [31:0] m, input logic en);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.m_in = m;
    ifc.en_in = en;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.m_in = ~m;
    ifc.en_in = ~en;
    check("busy_after_start", 32'(ifc.busy), 1);
    check("err_code_cleared", 32'(ifc.err_code), 0);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (ifc.busy && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (ifc.busy) flag("idle_wait_expired", 32'(k));
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [31:0] m, input logic en, input int delay,
                     input int noack, input int bad, input int exp_n,
                     input logic [3:0] ev);
    ack_delay = delay;
    no_ack_idx = noack;
    bad_idx = bad;
    byte_idx = 0;
    n_tx = 0;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(exp_byte(i, m, en));
    evt_q.push_back(ev);
    start_cmd(m, en);
    wait_idle(3000);
    check("tx_count", 32'(n_tx), 32'(exp_n));
    check("tx_queue_drained", 32'(exp_q.size()), 0);
    check("evt_queue_drained", 32'(evt_q.size()), 0);
    check("busy_after_end", 32'(ifc.busy), 0);
    check("err_code_final", 32'(ifc.err_code), 32'(ev[1:0]));
  endtask

  initial begin
    int k;
    int lat;
    ifc.start = 1'b0;
    ifc.m_in = 32'd0;
    ifc.en_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_transmit", 32'(ifc.transmit), 0);
    check("rst_tx_byte", 32'(ifc.tx_byte), 0);
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_done_err", 32'({ifc.done, ifc.err}), 0);
    check("rst_err_code", 32'(ifc.err_code), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // happy path, ENABLE last
    run(32'h1234_5678, 1'b1, 20, -1, -1, 10, 4'b1000);
    // DISABLE last, zero word
    run(32'h0000_0000, 1'b0, 20, -1, -1, 10, 4'b1000);
    // ACK arrives while tx_busy still high
    run(32'hA5C3_0F96, 1'b1, 2, -1, -1, 10, 4'b1000);
    // no ACK after SET: timeout, ENABLE never sent
    run(32'h0102_0304, 1'b1, 20, 8, -1, 9, 4'b0101);
    lat = last_evt_cyc - last_tx_cyc;
    checks++;
    if (lat < TO - 1 || lat > TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d..%0d",
               lat, TO - 1, TO + 1);
    end
    // wrong reply after BYTE1 data
    run(32'hDEAD_BEEF, 1'b1, 20, -1, 3, 4, 4'b0110);

    // reset mid-sequence, with a stray start while busy beforehand
    ack_delay = 20;
    no_ack_idx = -1;
    bad_idx = -1;
    byte_idx = 0;
    n_tx = 0;
    for (int i = 0; i < 6; i++)
      exp_q.push_back(exp_byte(i, 32'hCAFE_F00D, 1'b1));
    start_cmd(32'hCAFE_F00D, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.m_in = 32'h0000_0000;
    ifc.en_in = 1'b0;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    k = 0;
    while (n_tx < 6 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_tx < 6) flag("reset_wait_expired", 32'(n_tx));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_transmit", 32'(ifc.transmit), 0);
    check("mid_rst_tx_byte", 32'(ifc.tx_byte), 0);
    check("mid_rst_busy", 32'(ifc.busy), 0);
    check("mid_rst_done_err", 32'({ifc.done, ifc.err}), 0);
    check("mid_rst_err_code", 32'(ifc.err_code), 0);
    check("pre_rst_tx_count", 32'(n_tx), 6);
    check("pre_rst_tx_queue", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_no_evt", 32'({ifc.done, ifc.err}), 0);

    // restart from BYTE0 after reset
    run(32'h0A0B_0C0D, 1'b0, 20, -1, -1, 10, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_cmd_master.md
Name: dds_cmd_master

Overview:
- UART command initiator; the counterpart of the DDS command responder.
- Serialises a 32-bit tuning word plus an enable/disable request into the command byte protocol. Sends SET, then ENABLE or DISABLE, and waits for an ACK byte after each complete command.
- Sits between a local controller (self-test, or a board driving a second DDS board) and the UART tx/rx pair.

Parameters:
- ACK_TIMEOUT, 1200000, clocks to wait for ACK after the final byte of a command is launched (100 ms at 12 MHz).
- CNT_W, $clog2(ACK_TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- m_in  in  32  tuning word, captured at start
- en_in  in  1  1 = send ENABLE last, 0 = send DISABLE last; captured at start
- transmit  out  1  one-cycle pulse to UART tx
- tx_byte  out  8  byte to send, valid with transmit and held until the next pulse
- tx_busy  in  1  UART tx busy
- received  in  1  one-cycle UART rx strobe
- rx_byte  in  8  received byte, valid with received
- busy  out  1  high from the start acceptance cycle until done or err
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on failure
- err_code  out  2  0 none, 1 timeout, 2 unexpected response; held until the next start

Behaviour:
- Reset (async, rst_n=0): state IDLE; transmit, tx_byte, busy, done, err, err_code, counters all 0. A reset mid-sequence aborts silently with no err pulse.
- Sequence, in order: [BYTE0, m[7:0]], [BYTE1, m[15:8]], [BYTE2, m[23:16]], [BYTE3, m[31:24]], [SET], [EN_in ? ENABLE : DISABLE].
  - Brackets are commands; the ACK wait follows the last byte of each bracket.
  - 6 ACKs total; 10 bytes transmitted.
- Step index is 0..5; a phase bit selects the cmd byte or the data byte for steps 0-3.
- States:
  - IDLE: start=1 -> capture m_in/en_in, busy=1, clear err_code -> LOAD.
  - LOAD: drive tx_byte for the current step/phase -> SEND.
  - SEND: wait for tx_busy=0, then pulse transmit for 1 cycle -> GUARD. If this is the last byte of a command, clear the ack flag and load the timeout counter with ACK_TIMEOUT.
  - GUARD: 1 cycle, tx_busy ignored (UART latency) -> WAIT_TX.
  - WAIT_TX: wait for tx_busy=0. Not last byte: advance phase -> LOAD. Last byte -> WAIT_ACK.
  - WAIT_ACK: ack flag set -> step+1; step 5 done -> DONE, else LOAD. Counter reaches 0 -> ERR code 1.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
  - ERR: err=1 for 1 cycle, busy=0, err_code held -> IDLE.
- ACK detection is armed from the transmit pulse of a command's last byte. This is required because the responder can answer before tx_busy falls.
  - received && rx_byte==ACK sets the ack flag in GUARD, WAIT_TX and WAIT_ACK.
  - received with any other byte while armed -> ERR code 2 immediately.
  - received while not armed (IDLE, or mid-command before the last byte) is ignored.
- The timeout counter decrements every cycle while armed. It saturates at 0 and is never reloaded by stray bytes.
- start while busy is ignored; m_in/en_in changes after capture are ignored.
- ACK and timeout expiry in the same cycle: ACK wins.
- No retries: the controller must reissue start.

Decomposition:
- Shared header commands.vh (existing): BYTE0-3, ENABLE, DISABLE, SET, ACK codes. Error code constants ERR_NONE/ERR_TIMEOUT/ERR_BADRSP are added there as well.
- State encodings are local localparams.
- One natural sub-module: ack_watchdog. It holds the arm/clear ack flag, bad-byte detect and timeout down-counter, and exposes ack_ok, bad_rsp and timeout.

Test Plan:
- Happy path, m_in=0x12345678, en_in=1, model UART ACKs 20 cycles after each command -> tx bytes BYTE0,78,BYTE1,56,BYTE2,34,BYTE3,12,SET,ENABLE. Exactly 10 transmit pulses and 1 done pulse; busy low afterwards; err_code=0.
- en_in=0, m_in=0 -> final byte DISABLE, done pulse, no err.
- Early ACK: the model returns ACK while tx_busy is still high after the data byte -> accepted; sequence proceeds without timeout.
- No ACK after SET, ACK_TIMEOUT=50 -> err pulse 50 (+-1) cycles after the SET transmit. err_code=1, no ENABLE byte sent, busy=0.
- Bad response: reply 0x55 instead of ACK after BYTE1 data -> err pulse, err_code=2, only 4 bytes transmitted.
- rst_n low during BYTE2 data wait, with start asserted again while busy beforehand -> the extra start has no effect. All outputs are 0 during reset, and a new start afterwards restarts from BYTE0.
